// File: rtl/signed_display_pkg.sv
// Shared types and constants for the signed multiplexed display scanner.
package signed_display_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    // Active-low {a..g} glyphs for magnitudes 0..8.
    localparam logic [6:0] GLYPH [0:8] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000
    };

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/signed_nibble_decoder.sv
// Combinational decode of a 4-bit two's-complement value into sign and magnitude glyphs.
module signed_nibble_decoder
    import signed_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] sign,
    output logic [6:0] mag
);

    logic [3:0] magnitude;

    // Negate negatives; -8 wraps to 4'b1000 which reads as magnitude 8.
    always_comb begin
        magnitude = value[3] ? (~value + 4'd1) : value;
        sign      = value[3] ? SEG_MINUS : SEG_BLANK;
        mag       = GLYPH[magnitude];
    end

endmodule

// File: rtl/signed_display_scanner.sv
// Multiplexed signed-digit display scanner with double-buffered value bank.
module signed_display_scanner
    import signed_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                   wr_data,
    input  logic                         commit,
    output logic                         commit_pending,
    output logic                         frame_done,
    output logic [NUM_DIGITS-1:0]        dig_n,
    output logic [6:0]                   seg_sign,
    output logic [6:0]                   seg_mag
);

    localparam int unsigned IW   = clog2(NUM_DIGITS);
    localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW   = clog2(MAXC + 1);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_c;
    logic            frame_end_c;
    logic            copy_c;
    logic            addr_ok_c;

    logic [3:0]      shadow [NUM_DIGITS];
    logic [3:0]      active [NUM_DIGITS];

    logic [6:0]      dec_sign;
    logic [6:0]      dec_mag;

    // Scan position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next scan position; disabling parks the scanner at BLANK, digit 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(1);
        last_c      = (state_q == ST_DRIVE) ? (cnt_q == DWELL_LAST) : (cnt_q == BLANK_LAST);
        frame_end_c = enable && (state_q == ST_DRIVE) && last_c && (idx_q == IDX_LAST);
        if (!enable) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (last_c) begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_DRIVE;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end
    end

    // Copy on a frame end, or on any disabled edge so a dark display never holds a stale commit.
    always_comb begin
        copy_c    = commit_pending && (frame_end_c || !enable);
        addr_ok_c = 32'(wr_addr) < NUM_DIGITS;
    end

    // Shadow/active banks; copy sees pre-edge shadow, so a same-edge write lands after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (copy_c) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en && addr_ok_c) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

    // Commit handshake and frame pulse; a new commit wins over a same-edge copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_pending <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            if (commit) begin
                commit_pending <= 1'b1;
            end else if (copy_c) begin
                commit_pending <= 1'b0;
            end
        end
    end

    signed_nibble_decoder u_decoder (
        .value (active[idx_q]),
        .sign  (dec_sign),
        .mag   (dec_mag)
    );

    // Display outputs follow the scan state one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig_n    <= '1;
            seg_sign <= SEG_BLANK;
            seg_mag  <= SEG_BLANK;
        end else if (state_q == ST_DRIVE) begin
            dig_n    <= ~(NUM_DIGITS'(1) << idx_q);
            seg_sign <= dec_sign;
            seg_mag  <= dec_mag;
        end else begin
            dig_n    <= '1;
            seg_sign <= SEG_BLANK;
            seg_mag  <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_signed_display_scanner.sv
// Self-checking bench for signed_display_scanner against a position-arithmetic reference model.
module tb_signed_display_scanner;

    localparam int unsigned N     = 2;
    localparam int unsigned D     = 4;
    localparam int unsigned B     = 2;
    localparam int          PER   = int'(B + D);
    localparam int          FRAME = int'(N) * PER;

    logic         clk = 1'b0;
    logic         reset, enable, wr_en, commit;
    logic [0:0]   wr_addr;
    logic [3:0]   wr_data;
    logic         commit_pending, frame_done;
    logic [N-1:0] dig_n;
    logic [6:0]   seg_sign, seg_mag;

    // Second instance with three digits so an out-of-range address is expressible.
    logic         reset_b, enable_b, wr_en_b, commit_b;
    logic [1:0]   wr_addr_b;
    logic [3:0]   wr_data_b;
    logic         commit_pending_b, frame_done_b;
    logic [2:0]   dig_n_b;
    logic [6:0]   seg_sign_b, seg_mag_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: scan position since the scan (re)started.
    int           m_pos;
    logic [3:0]   m_shadow [N];
    logic [3:0]   m_active [N];
    logic         m_pending, m_fd;
    logic [N-1:0] m_dig;
    logic [6:0]   m_sign, m_mag;

    always #5 clk = ~clk;

    signed_display_scanner #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
        .frame_done(frame_done), .dig_n(dig_n), .seg_sign(seg_sign), .seg_mag(seg_mag)
    );

    signed_display_scanner #(.NUM_DIGITS(3), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .commit(commit_b), .commit_pending(commit_pending_b),
        .frame_done(frame_done_b), .dig_n(dig_n_b), .seg_sign(seg_sign_b), .seg_mag(seg_mag_b)
    );

    function automatic logic [6:0] ref_sign(input logic [3:0] v);
        return v[3] ? 7'b1111110 : 7'b1111111;
    endfunction

    function automatic logic [6:0] ref_mag(input logic [3:0] v);
        logic [6:0] tbl [0:8];
        int s;
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
        s = v[3] ? int'(v) - 16 : int'(v);
        if (s < 0) s = -s;
        return tbl[s];
    endfunction

    task automatic model_reset();
        m_pos = 0; m_pending = 1'b0; m_fd = 1'b0;
        m_dig = '1; m_sign = 7'b1111111; m_mag = 7'b1111111;
        for (int i = 0; i < int'(N); i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int  slot, dig;
        bit  fe, cp;
        if (reset) begin
            model_reset();
            return;
        end
        slot = m_pos % PER;
        dig  = (m_pos / PER) % int'(N);
        if (slot >= int'(B)) begin
            m_dig  = ~(N'(1) << dig);
            m_sign = ref_sign(m_active[dig]);
            m_mag  = ref_mag(m_active[dig]);
        end else begin
            m_dig = '1; m_sign = 7'b1111111; m_mag = 7'b1111111;
        end
        fe   = enable && (m_pos == FRAME - 1);
        m_fd = fe;
        cp   = m_pending && (fe || !enable);
        if (cp) begin
            for (int i = 0; i < int'(N); i++) m_active[i] = m_shadow[i];
        end
        if (commit) m_pending = 1'b1;
        else if (cp) m_pending = 1'b0;
        if (wr_en && int'(wr_addr) < int'(N)) m_shadow[wr_addr] = wr_data;
        m_pos = enable ? (m_pos + 1) % FRAME : 0;
    endtask

    task automatic check_all();
        checks++;
        assert (dig_n === m_dig) else begin
            errors++; $error("FAIL dig_n got=%b exp=%b t=%0t", dig_n, m_dig, $time);
        end
        checks++;
        assert (seg_sign === m_sign) else begin
            errors++; $error("FAIL seg_sign got=%b exp=%b t=%0t", seg_sign, m_sign, $time);
        end
        checks++;
        assert (seg_mag === m_mag) else begin
            errors++; $error("FAIL seg_mag got=%b exp=%b t=%0t", seg_mag, m_mag, $time);
        end
        checks++;
        assert (frame_done === m_fd) else begin
            errors++; $error("FAIL frame_done got=%b exp=%b t=%0t", frame_done, m_fd, $time);
        end
        checks++;
        assert (commit_pending === m_pending) else begin
            errors++; $error("FAIL commit_pending got=%b exp=%b t=%0t", commit_pending, m_pending, $time);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model, edge, sample 1 time unit later, clear single-cycle pulses.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
        check_all();
    endtask

    task automatic run_to_frame_done(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        chk("frame_done_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic write(input logic a, input logic [3:0] d, input logic c);
        wr_en = 1'b1; wr_addr = a; wr_data = d; commit = c;
        step();
    endtask

    initial begin
        logic [N-1:0] e_dig;
        logic [6:0]   e_sign, e_mag;
        int           n, driven;

        reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        reset_b = 1'b1; enable_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; commit_b = 1'b0;
        model_reset();
        @(negedge clk);

        // 1. Reset, scan a while, then reset mid-scan for 3 clocks.
        repeat (3) step();
        reset = 1'b0; reset_b = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        repeat (3) step();
        chk("reset_dig_n", 32'(dig_n), 32'h3);
        chk("reset_seg_mag", 32'(seg_mag), 32'h7f);
        chk("reset_pending", 32'(commit_pending), 32'd0);
        reset = 1'b0;
        step(); step();
        chk("restart_dark", 32'(dig_n), 32'h3);
        step();
        chk("restart_digit0", 32'(dig_n), 32'h2);

        // 2. +3 / -5 committed; full frame after the copy.
        write(1'b0, 4'b0011, 1'b0);
        write(1'b1, 4'b1011, 1'b1);
        chk("commit_set", 32'(commit_pending), 32'd1);
        run_to_frame_done(30);
        chk("commit_cleared", 32'(commit_pending), 32'd0);
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (k < 2 || (k >= 6 && k < 8)) begin
                e_dig = 2'b11; e_sign = 7'b1111111; e_mag = 7'b1111111;
            end else if (k < 6) begin
                e_dig = 2'b10; e_sign = 7'b1111111; e_mag = 7'b0000110;
            end else begin
                e_dig = 2'b01; e_sign = 7'b1111110; e_mag = 7'b0100100;
            end
            chk("frame_dig_n", 32'(dig_n), 32'(e_dig));
            chk("frame_sign", 32'(seg_sign), 32'(e_sign));
            chk("frame_mag", 32'(seg_mag), 32'(e_mag));
        end

        // 3. Uncommitted write stays invisible, then appears after the next frame_done.
        write(1'b0, 4'b0111, 1'b0);
        repeat (3 * FRAME) step();
        commit = 1'b1;
        step();
        chk("commit3_set", 32'(commit_pending), 32'd1);
        run_to_frame_done(30);
        chk("commit3_cleared", 32'(commit_pending), 32'd0);
        repeat (3) step();
        chk("plus7_dig", 32'(dig_n), 32'h2);
        chk("plus7_mag", 32'(seg_mag), 32'(7'b0001111));

        // 4. Commit exactly on the frame-end clock defers to the following frame.
        write(1'b1, 4'b0110, 1'b0);
        n = 0;
        while (m_pos != FRAME - 1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        commit = 1'b1;
        step();
        chk("fe_commit_frame_done", 32'(frame_done), 32'd1);
        chk("fe_commit_pending", 32'(commit_pending), 32'd1);
        run_to_frame_done(30);
        chk("fe_commit_applied", 32'(commit_pending), 32'd0);

        // 5. -8 shows minus and all-segments-on magnitude.
        write(1'b1, 4'b1000, 1'b1);
        run_to_frame_done(30);
        repeat (9) step();
        chk("neg8_dig", 32'(dig_n), 32'h1);
        chk("neg8_sign", 32'(seg_sign), 32'(7'b1111110));
        chk("neg8_mag", 32'(seg_mag), 32'(7'b0000000));

        // 6. Disable mid-DRIVE of digit 1 with a commit pending, then re-enable.
        n = 0;
        while (m_pos != 0 && n < 2 * FRAME) begin
            step();
            n++;
        end
        write(1'b0, 4'b0001, 1'b1);
        while (m_pos != PER + int'(B) + 1 && n < 4 * FRAME) begin
            step();
            n++;
        end
        enable = 1'b0;
        step();
        chk("disable_lag_dig", 32'(dig_n), 32'h1);
        chk("disable_copy", 32'(commit_pending), 32'd0);
        step();
        chk("disable_dark", 32'(dig_n), 32'h3);
        repeat (3) step();
        enable = 1'b1;
        step(); step();
        chk("reenable_blank", 32'(dig_n), 32'h3);
        step();
        chk("reenable_digit0", 32'(dig_n), 32'h2);
        chk("reenable_mag", 32'(seg_mag), 32'(7'b1001111));

        // 7. Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = 1'($urandom_range(0, 1));
            wr_data = 4'($urandom);
            commit  = ($urandom_range(0, 14) == 0);
            step();
        end
        reset = 1'b0; enable = 1'b1;

        // 8. Three-digit instance: out-of-range address ignored.
        wr_en_b = 1'b1; wr_addr_b = 2'd3; wr_data_b = 4'b0101;
        step();
        wr_addr_b = 2'd2; wr_data_b = 4'b1111; commit_b = 1'b1;
        step();
        wr_en_b = 1'b0; commit_b = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done_b !== 1'b1 && n < 60);
        chk("b_frame_done_wait", 32'(frame_done_b), 32'd1);
        driven = 0;
        for (int k = 0; k < 18; k++) begin
            step();
            if (dig_n_b == 3'b011) begin
                driven++;
                chk("b_slot2_sign", 32'(seg_sign_b), 32'(7'b1111110));
                chk("b_slot2_mag", 32'(seg_mag_b), 32'(7'b1001111));
            end else if (dig_n_b == 3'b110 || dig_n_b == 3'b101) begin
                driven++;
                chk("b_slot01_sign", 32'(seg_sign_b), 32'(7'b1111111));
                chk("b_slot01_mag", 32'(seg_mag_b), 32'(7'b0000001));
            end else begin
                chk("b_dark_dig", 32'(dig_n_b), 32'h7);
            end
        end
        chk("b_driven_count", 32'(driven), 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
